// File: rtl/corr_pkg.sv
// Shared definitions for the correlator input conditioning path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package corr_pkg;

    typedef logic [1:0] corr_mode_t;

    localparam corr_mode_t CORR_MODE_LEVEL      = 2'd0;
    localparam corr_mode_t CORR_MODE_RISE       = 2'd1;
    localparam corr_mode_t CORR_MODE_ANYEDGE    = 2'd2;
    localparam corr_mode_t CORR_MODE_HIGHSTICKY = 2'd3;

endpackage

// File: rtl/corr_input_chan.sv
// One input channel: synchroniser, glitch filter, event capture and multi-event flag.
// Latency: SYNC_STAGES+1 cycles to the event, +1 cycle to the registered sample (N=0).
// Backpressure: none; i_strobe consumes one sample per strobe, i_cg freezes all state.
module corr_input_chan
    import corr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cg,
    input  logic                i_async,
    input  logic [1:0]          i_mode,
    input  logic                i_modeClr,
    input  logic [FILTER_W-1:0] i_filterLen,
    input  logic                i_strobe,
    output logic                o_sample,
    output logic                o_multi
);

    localparam logic [FILTER_W-1:0] CNT_ONE = 1;

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   syncOut;
    logic                   fQ;
    logic                   fD;
    logic [FILTER_W-1:0]    cntQ;
    logic [FILTER_W-1:0]    cntD;
    logic                   evt;
    logic                   capQ;
    logic                   capNow;
    logic [1:0]             nQ;
    logic [1:0]             nNow;
    logic [1:0]             nSum;
    logic [1:0]             nSat;
    logic                   isLevel;

    assign syncOut = syncQ[SYNC_STAGES-1];
    assign isLevel = (i_mode == CORR_MODE_LEVEL);

    // Glitch filter: f only follows s after N+1 consecutive differing cycles.
    always_comb begin
        fD   = fQ;
        cntD = cntQ;
        if (syncOut == fQ) begin
            cntD = '0;
        end else if (cntQ == i_filterLen) begin
            fD   = syncOut;
            cntD = '0;
        end else begin
            cntD = cntQ + CNT_ONE;
        end
    end

    // Event generation from the filtered value and its next value.
    always_comb begin
        evt = 1'b0;
        case (i_mode)
            CORR_MODE_RISE:       evt = fD & ~fQ;
            CORR_MODE_ANYEDGE:    evt = fD ^ fQ;
            CORR_MODE_HIGHSTICKY: evt = fD;
            default:              evt = 1'b0;
        endcase
    end

    // Pending capture state; a mode change discards what was gathered under the old mode.
    always_comb begin
        capNow = capQ & ~i_modeClr;
        nNow   = i_modeClr ? 2'd0 : nQ;
        nSum   = nNow + {1'b0, evt};
        nSat   = (nSum >= 2'd2) ? 2'd2 : nSum;
    end

    // Synchroniser chain and filter state.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            syncQ <= '0;
            fQ    <= 1'b0;
            cntQ  <= '0;
        end else if (i_cg) begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], i_async};
            fQ    <= fD;
            cntQ  <= cntD;
        end
    end

    // Capture accumulation between strobes and registered sample on each strobe.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            capQ     <= 1'b0;
            nQ       <= 2'd0;
            o_sample <= 1'b0;
            o_multi  <= 1'b0;
        end else if (i_cg) begin
            if (i_strobe) begin
                o_sample <= isLevel ? fD : (capNow | evt);
                o_multi  <= ~isLevel & (nSum >= 2'd2);
                capQ     <= 1'b0;
                nQ       <= 2'd0;
            end else begin
                capQ     <= capNow | evt;
                nQ       <= nSat;
            end
        end
    end

endmodule

// File: rtl/corr_input_cond.sv
// Conditions the raw X/Y event inputs into one sample per correlator strobe.
// Latency: SYNC_STAGES+2 cycles from async edge to o_x/o_y with N=0 and an immediate strobe.
// Backpressure: none; outputs update only on strobe cycles, i_cg freezes all state.
module corr_input_cond
    import corr_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_W    = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_cg,
    input  logic                i_xAsync,
    input  logic                i_yAsync,
    input  logic [1:0]          i_mode,
    input  logic [FILTER_W-1:0] i_filterLen,
    input  logic                i_strobe,
    output logic                o_x,
    output logic                o_y,
    output logic                o_multiX,
    output logic                o_multiY
);

    logic [1:0] modeQ;
    logic       modeClr;

    assign modeClr = (i_mode != modeQ);

    // Registered copy of the mode, used to spot mode changes.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            modeQ <= CORR_MODE_LEVEL;
        end else if (i_cg) begin
            modeQ <= i_mode;
        end
    end

    corr_input_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W)
    ) u_chanX (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cg        (i_cg),
        .i_async     (i_xAsync),
        .i_mode      (i_mode),
        .i_modeClr   (modeClr),
        .i_filterLen (i_filterLen),
        .i_strobe    (i_strobe),
        .o_sample    (o_x),
        .o_multi     (o_multiX)
    );

    corr_input_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_W    (FILTER_W)
    ) u_chanY (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_cg        (i_cg),
        .i_async     (i_yAsync),
        .i_mode      (i_mode),
        .i_modeClr   (modeClr),
        .i_filterLen (i_filterLen),
        .i_strobe    (i_strobe),
        .o_sample    (o_y),
        .o_multi     (o_multiY)
    );

endmodule
